// File: rtl/seg7_reader_if.sv
// Segment-bus capture interface: the sampling side (en, seg_in) and the decoded
// results coming back from seg7_reader.
interface seg7_reader_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [6:0]       seg_in;
    logic [3:0]       digit_out;
    logic             digit_valid;
    logic             invalid;
    logic             blank;
    logic [CNT_W-1:0] change_count;

    modport master (
        output en, seg_in,
        input  digit_out, digit_valid, invalid, blank, change_count
    );

    modport slave (
        input  en, seg_in,
        output digit_out, digit_valid, invalid, blank, change_count
    );
endinterface

// File: rtl/seg7_reader.sv
// Debounced 7-segment reader: waits for a stable segment pattern, decodes it back
// to a hex digit, and counts every newly accepted valid digit.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input logic          clk,
    input logic          rst,
    seg7_reader_if.slave bus
);

    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_EMIT
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         seg_q, seg_d;
    logic [STAB_W-1:0]  stab_q, stab_d;
    logic [6:0]         acc_q, acc_d;
    logic [3:0]         digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               invalid_q, invalid_d;
    logic               blank_q, blank_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [4:0]         dec;

    // Returns {recognised, digit}; blank and unknown patterns both report 0 in the top bit.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] r;
        r = 5'h00;
        case (pat)
            7'h3F: r = {1'b1, 4'h0};
            7'h06: r = {1'b1, 4'h1};
            7'h5B: r = {1'b1, 4'h2};
            7'h4F: r = {1'b1, 4'h3};
            7'h66: r = {1'b1, 4'h4};
            7'h6D: r = {1'b1, 4'h5};
            7'h7D: r = {1'b1, 4'h6};
            7'h07: r = {1'b1, 4'h7};
            7'h7F: r = {1'b1, 4'h8};
            7'h6F: r = {1'b1, 4'h9};
            7'h77: r = {1'b1, 4'hA};
            7'h7C: r = {1'b1, 4'hB};
            7'h39: r = {1'b1, 4'hC};
            7'h5E: r = {1'b1, 4'hD};
            7'h79: r = {1'b1, 4'hE};
            7'h71: r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        stab_d    = stab_q;
        acc_d     = acc_q;
        digit_d   = digit_q;
        valid_d   = 1'b0;
        invalid_d = 1'b0;
        blank_d   = blank_q;
        count_d   = count_q;
        dec       = decode_seg(seg_q);

        if (bus.en) begin
            seg_d = bus.seg_in;
            if (bus.seg_in != seg_q) begin
                stab_d  = '0;
                state_d = ST_SETTLE;
            end else if (state_q == ST_SETTLE) begin
                if (stab_q == STAB_MAX) begin
                    // A pattern that merely returns to the accepted one is not an event.
                    if (seg_q != acc_q) begin
                        state_d = ST_EMIT;
                        acc_d   = seg_q;
                        if (seg_q == 7'h00) begin
                            blank_d = 1'b1;
                        end else begin
                            blank_d = 1'b0;
                            if (dec[4]) begin
                                digit_d = dec[3:0];
                                valid_d = 1'b1;
                                count_d = count_q + CNT_W'(1);
                            end else begin
                                invalid_d = 1'b1;
                            end
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end else if (state_q == ST_EMIT) begin
                state_d = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_WAIT;
            seg_q     <= 7'h00;
            stab_q    <= '0;
            acc_q     <= 7'h00;
            digit_q   <= 4'h0;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
            blank_q   <= 1'b1;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            stab_q    <= stab_d;
            acc_q     <= acc_d;
            digit_q   <= digit_d;
            valid_q   <= valid_d;
            invalid_q <= invalid_d;
            blank_q   <= blank_d;
            count_q   <= count_d;
        end
    end

    assign bus.digit_out    = digit_q;
    assign bus.digit_valid  = valid_q;
    assign bus.invalid      = invalid_q;
    assign bus.blank        = blank_q;
    assign bus.change_count = count_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Drives two seg7_reader instances (4-cycle/8-bit and 1-cycle/2-bit) with the same
// segment stream and compares them every cycle against a run-length reference model.
module tb_seg7_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_reader_if #(.CNT_W(8)) busA ();
    seg7_reader_if #(.CNT_W(2)) busB ();

    seg7_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    seg7_reader #(.STABLE_CYCLES(1), .CNT_W(2)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    logic [6:0] segTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state per instance: last sample, length of its current run, accepted
    // pattern and the expected outputs after the latest edge.
    int unsigned mStab [2];
    int unsigned mMod  [2];
    int unsigned mLast [2];
    int unsigned mRun  [2];
    int unsigned mAcc  [2];
    int unsigned mDigit[2];
    int unsigned mCount[2];
    int unsigned mBlank[2];
    int unsigned mValid[2];
    int unsigned mInval[2];

    function automatic int lookupDigit(input int unsigned pat);
        for (int d = 0; d < 16; d++) begin
            if (int'(segTable[d]) == int'(pat)) return d;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        else
            passCount++;
    endtask

    // A pattern is accepted on the edge where its run of identical enabled samples
    // reaches STABLE_CYCLES+1; runs that keep going never trigger a second time.
    task automatic modelStep(input int i, input logic [6:0] seg, input logic enV, input logic rstV);
        int d;
        mValid[i] = 0;
        mInval[i] = 0;
        if (rstV) begin
            mLast[i]  = 0;
            mRun[i]   = mStab[i] + 2;
            mAcc[i]   = 0;
            mDigit[i] = 0;
            mCount[i] = 0;
            mBlank[i] = 1;
        end else if (enV) begin
            if (int'(seg) == int'(mLast[i])) begin
                if (mRun[i] < mStab[i] + 2) mRun[i]++;
            end else begin
                mLast[i] = seg;
                mRun[i]  = 1;
            end
            if (mRun[i] == mStab[i] + 1 && mLast[i] != mAcc[i]) begin
                mAcc[i] = mLast[i];
                d = lookupDigit(mLast[i]);
                if (mLast[i] == 0) begin
                    mBlank[i] = 1;
                end else begin
                    mBlank[i] = 0;
                    if (d >= 0) begin
                        mDigit[i] = d;
                        mCount[i] = (mCount[i] + 1) % mMod[i];
                        mValid[i] = 1;
                    end else begin
                        mInval[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("A_digit",   32'(busA.digit_out),    mDigit[0]);
        checkOutput("A_valid",   32'(busA.digit_valid),  mValid[0]);
        checkOutput("A_invalid", 32'(busA.invalid),      mInval[0]);
        checkOutput("A_blank",   32'(busA.blank),        mBlank[0]);
        checkOutput("A_count",   32'(busA.change_count), mCount[0]);
        checkOutput("B_digit",   32'(busB.digit_out),    mDigit[1]);
        checkOutput("B_valid",   32'(busB.digit_valid),  mValid[1]);
        checkOutput("B_invalid", 32'(busB.invalid),      mInval[1]);
        checkOutput("B_blank",   32'(busB.blank),        mBlank[1]);
        checkOutput("B_count",   32'(busB.change_count), mCount[1]);
    endtask

    // One clock: drive inputs away from the edge, clock, update the model, then compare.
    task automatic applyStimulus(input logic [6:0] seg, input logic enV, input logic rstV);
        busA.seg_in = seg;
        busA.en     = enV;
        busB.seg_in = seg;
        busB.en     = enV;
        rst         = rstV;
        @(posedge clk);
        modelStep(0, seg, enV, rstV);
        modelStep(1, seg, enV, rstV);
        #1;
        checkAll();
    endtask

    task automatic holdPattern(input logic [6:0] seg, input int cycles);
        for (int c = 0; c < cycles; c++) applyStimulus(seg, 1'b1, 1'b0);
    endtask

    int validPulses;
    int invalidPulses;
    logic [1:0] wrapSeq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        mStab[0] = 4; mMod[0] = 256;
        mStab[1] = 1; mMod[1] = 4;
        busA.seg_in = 7'h00; busA.en = 1'b1;
        busB.seg_in = 7'h00; busB.en = 1'b1;
        #2;

        for (int c = 0; c < 10; c++) applyStimulus(7'h00, 1'b1, 1'b1);
        checkOutput("rst_blank", 32'(busA.blank), 32'd1);
        checkOutput("rst_digit", 32'(busA.digit_out), 32'd0);
        holdPattern(7'h00, 3);

        // 0x4F from edge k: strobe visible only in the cycle after edge k+4.
        validPulses = 0;
        for (int c = 0; c < 7; c++) begin
            applyStimulus(7'h4F, 1'b1, 1'b0);
            if (busA.digit_valid) begin
                validPulses++;
                checkOutput("lat_edge", 32'(c), 32'd4);
            end
        end
        checkOutput("pulse_3", 32'(validPulses), 32'd1);
        checkOutput("digit_3", 32'(busA.digit_out), 32'd3);
        checkOutput("count_3", 32'(busA.change_count), 32'd1);
        checkOutput("blank_3", 32'(busA.blank), 32'd0);

        // Short glitch returning to the accepted pattern leaves no trace on the 4-cycle reader.
        validPulses = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus((c < 2) ? 7'h06 : 7'h4F, 1'b1, 1'b0);
            if (busA.digit_valid || busA.invalid) validPulses++;
        end
        checkOutput("glitch_events", 32'(validPulses), 32'd0);
        checkOutput("glitch_count", 32'(busA.change_count), 32'd1);

        invalidPulses = 0;
        for (int c = 0; c < 7; c++) begin
            applyStimulus(7'h12, 1'b1, 1'b0);
            if (busA.invalid) invalidPulses++;
        end
        checkOutput("inv_pulses", 32'(invalidPulses), 32'd1);
        checkOutput("inv_digit", 32'(busA.digit_out), 32'd3);
        holdPattern(7'h7C, 7);
        checkOutput("digit_b", 32'(busA.digit_out), 32'hB);
        checkOutput("count_b", 32'(busA.change_count), 32'd2);
        holdPattern(7'h00, 7);
        checkOutput("blank_again", 32'(busA.blank), 32'd1);

        for (int c = 0; c < 10; c++) applyStimulus(7'h7F, 1'b0, 1'b0);
        checkOutput("en_frozen", 32'(busA.digit_out), 32'hB);
        holdPattern(7'h7F, 7);
        checkOutput("digit_8", 32'(busA.digit_out), 32'd8);

        // Counter wrap on the 2-bit instance.
        applyStimulus(7'h00, 1'b1, 1'b1);
        for (int p = 0; p < 5; p++) begin
            holdPattern((p % 2 == 0) ? 7'h3F : 7'h06, 6);
            checkOutput("wrap_seq", 32'(busB.change_count), 32'(wrapSeq[p]));
        end

        // Reset while the 4-cycle reader is mid-settle.
        holdPattern(7'h5B, 2);
        applyStimulus(7'h5B, 1'b1, 1'b1);
        checkOutput("rst_mid_valid", 32'(busA.digit_valid), 32'd0);
        checkOutput("rst_mid_count", 32'(busA.change_count), 32'd0);
        checkOutput("rst_mid_blank", 32'(busA.blank), 32'd1);

        for (int s = 0; s < 250; s++) begin
            logic [6:0] pat;
            int sel;
            int hold;
            sel = $urandom_range(0, 9);
            if (sel < 6)       pat = segTable[$urandom_range(0, 15)];
            else if (sel == 6) pat = 7'h00;
            else               pat = 7'($urandom_range(0, 127));
            hold = $urandom_range(1, 7);
            for (int c = 0; c < hold; c++)
                applyStimulus(pat, ($urandom_range(0, 9) != 0), ($urandom_range(0, 299) == 0));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
